// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit FSM state type, common to the
// scheduler and the baud-rate generator.
package uart_pkg;

    localparam int UART_DATA_BITS = 32'sd8;
    localparam int UART_BAUD      = 32'sd115200;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PENDING = 3'd1,
        START   = 3'd2,
        DATA    = 3'd3,
        STOP    = 3'd4
    } tx_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester strictly after
// the pointer, wrapping modulo N. The pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] pointer_i,
    input  logic          enable_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o
);

    int            sum_s;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Scan candidates in priority order pointer+1 .. pointer+N (mod N).
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_s     = 1'b0;
        sum_s       = 0;
        cand_s      = '0;
        for (int k = 1; k <= N; k++) begin
            sum_s = int'(pointer_i) + k;
            if (sum_s >= N) begin
                sum_s = sum_s - N;
            end else begin
                sum_s = sum_s;
            end
            cand_s = IW'(sum_s);
            if (enable_i && !found_s && req_i[cand_s]) begin
                found_s         = 1'b1;
                grant_o[cand_s] = 1'b1;
                grant_idx_o     = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 8N1 UART serializer between NUM_REQ byte
// sources; bit timing comes from the external txclk_en baud tick.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int DATA_BITS = UART_DATA_BITS
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         txclk_en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         tx,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id
);

    localparam int         IW       = $clog2(NUM_REQ);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_t            state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        grant_id_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           cnt_q;
    logic                 tx_q;
    logic                 busy_q;

    logic [NUM_REQ-1:0]   grant_s;
    logic [IW-1:0]        grant_idx_s;
    logic                 arb_en_s;
    logic [DATA_BITS-1:0] bytes_s [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign bytes_s[g] = req_data[g*DATA_BITS +: DATA_BITS];
    end

    // The ready pulse must coincide with the valid it answers, so it is the
    // arbiter grant itself, masked while reset is asserted.
    assign arb_en_s = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .req_i       (req_valid),
        .pointer_i   (ptr_q),
        .enable_i    (arb_en_s),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    assign req_ready = grant_s;
    assign tx        = tx_q;
    assign busy      = busy_q;
    assign grant_id  = grant_id_q;

    // Frame sequencer; tx_q is loaded on each transition so the line is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= IW'(NUM_REQ - 1);
            grant_id_q <= '0;
            shift_q    <= '0;
            cnt_q      <= 3'd0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (|grant_s) begin
                        shift_q    <= bytes_s[grant_idx_s];
                        ptr_q      <= grant_idx_s;
                        grant_id_q <= grant_idx_s;
                        busy_q     <= 1'b1;
                        state_q    <= PENDING;
                    end
                end
                PENDING: begin
                    if (txclk_en) begin
                        tx_q    <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (txclk_en) begin
                        cnt_q   <= 3'd0;
                        tx_q    <= shift_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (txclk_en) begin
                        if (cnt_q == LAST_BIT) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            cnt_q   <= cnt_q + 3'd1;
                            shift_q <= {1'b0, shift_q[DATA_BITS-1:1]};
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                STOP: begin
                    if (txclk_en) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: per-cycle frame-level reference model, a vector
// table, hand-written corner sequences and a randomized requester phase.
module tb_uart_tx_scheduler;

    localparam int N  = 2;
    localparam int GW = $clog2(N);

    logic           clk       = 1'b0;
    logic           reset     = 1'b1;
    logic           txclk_en  = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [7:0]     req_byte [N];
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           tx;
    logic           busy;
    logic [GW-1:0]  grant_id;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = req_byte[i];
    end

    uart_tx_scheduler #(.NUM_REQ(N), .DATA_BITS(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .txclk_en  (txclk_en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx        (tx),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Baud tick: one cycle high every tick_p clocks.
    int tick_p   = 4;
    int tick_ctr = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tick_ctr >= tick_p - 1) tick_ctr = 0;
            else tick_ctr++;
            txclk_en = (tick_ctr == 0);
        end
    end

    // Reference model: who wins by round-robin, and which frame bit is on the
    // line given how many ticks remain until the frame ends.
    bit           m_busy = 1'b0;
    int           m_ptr  = N - 1;
    int           m_gid  = 0;
    int           m_tl   = 0;
    logic [9:0]   m_frame = 10'h3FF;
    logic [N-1:0] ready_seen = '0;
    int           ready_cnt = 0;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (ptr + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] exp_ready;
        logic         exp_tx;
        int           w;
        if (reset) begin
            check("reset outputs", 32'({req_ready, busy, tx, grant_id}),
                  32'({{N{1'b0}}, 1'b0, 1'b1, {GW{1'b0}}}));
            m_busy = 1'b0; m_ptr = N - 1; m_gid = 0; m_tl = 0;
            ready_seen = '0;
        end else begin
            exp_ready = '0;
            w = -1;
            if (!m_busy) w = rr_pick(m_ptr, req_valid);
            if (w >= 0) exp_ready[w] = 1'b1;
            exp_tx = (!m_busy || m_tl == 11) ? 1'b1 : m_frame[10 - m_tl];
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("busy/tx/grant_id", 32'({busy, tx, grant_id}), 32'({m_busy, exp_tx, GW'(m_gid)}));
            ready_seen = req_ready;
            if (req_ready != '0) ready_cnt++;
            if (w >= 0) begin
                m_busy = 1'b1; m_ptr = w; m_gid = w; m_tl = 11;
                m_frame = {1'b1, req_byte[w], 1'b0};
            end else if (m_busy && txclk_en) begin
                m_tl--;
                if (m_tl == 0) m_busy = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        req_valid = '0;
        tick_p = 4;
        repeat (2) cyc();
        reset = 1'b0;
    endtask

    task automatic wait_grant(input int bound, output int idx);
        idx = -1;
        for (int k = 0; k < bound; k++) begin
            cyc();
            if (ready_seen != '0) begin
                for (int i = 0; i < N; i++) if (ready_seen[i]) idx = i;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int bound);
        for (int k = 0; k < bound; k++) begin
            cyc();
            if (busy === 1'b0) break;
        end
        check("return to idle", 32'(busy), 32'd0);
    endtask

    // Samples the ten line bits mid-period; assumes a 4-clock tick period.
    task automatic capture_frame(output logic [9:0] line);
        int n;
        n = 0;
        line = 10'h3FF;
        while (tx !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("start bit seen", 32'(tx), 32'd0);
        @(negedge clk);
        line[0] = tx;
        for (int k = 1; k < 10; k++) begin
            repeat (4) @(negedge clk);
            line[k] = tx;
        end
    endtask

    typedef struct packed {
        logic [1:0] valid;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] exp_ready;
        logic       exp_gid;
        logic [9:0] exp_line;   // bit k = k-th bit on the line
    } vec_t;

    vec_t       tv [6];
    int         idx;
    int         n;
    int         m;
    int         base;
    int         exp_ord [4];
    logic [9:0] line;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        for (int i = 0; i < N; i++) req_byte[i] = 8'h00;
        tv[0] = '{2'b01, 8'hA5, 8'h00, 2'b01, 1'b0, 10'b1101001010};
        tv[1] = '{2'b10, 8'h00, 8'h3C, 2'b10, 1'b1, 10'b1001111000};
        tv[2] = '{2'b11, 8'h11, 8'h22, 2'b01, 1'b0, 10'b1000100010};
        tv[3] = '{2'b01, 8'h00, 8'h5A, 2'b01, 1'b0, 10'b1000000000};
        tv[4] = '{2'b10, 8'h00, 8'hFF, 2'b10, 1'b1, 10'b1111111110};
        tv[5] = '{2'b11, 8'h80, 8'h01, 2'b01, 1'b0, 10'b1100000000};
        exp_ord = '{0, 1, 0, 1};

        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;

        // Table: one accept from reset, then the full frame on the line.
        for (int t = 0; t < 6; t++) begin
            do_reset();
            req_byte[0] = tv[t].d0;
            req_byte[1] = tv[t].d1;
            req_valid   = tv[t].valid;
            wait_grant(6, idx);
            check("table ready", 32'(ready_seen), 32'(tv[t].exp_ready));
            check("table grant_id", 32'(grant_id), 32'(tv[t].exp_gid));
            req_valid = '0;
            capture_frame(line);
            check("table frame", 32'(line), 32'(tv[t].exp_line));
            wait_idle(100);
        end

        // Contention: both valid throughout, order alternates.
        do_reset();
        req_byte[0] = 8'h11;
        req_byte[1] = 8'h22;
        req_valid   = 2'b11;
        for (int g = 0; g < 4; g++) begin
            wait_grant(60, idx);
            check("rr order", 32'(idx), 32'(exp_ord[g]));
            check("rr grant_id", 32'(grant_id), 32'(exp_ord[g]));
            req_byte[exp_ord[g]] = req_byte[exp_ord[g]] + 8'h01;
        end
        req_valid = '0;
        wait_idle(100);

        // Starvation: req0 streams, req1 raised mid-frame wins the next slot.
        do_reset();
        req_byte[0] = 8'h33;
        req_valid   = 2'b01;
        wait_grant(6, idx);
        check("stream first", 32'(idx), 32'd0);
        req_byte[0] = 8'h34;
        repeat (10) cyc();
        req_byte[1]  = 8'h77;
        req_valid[1] = 1'b1;
        wait_grant(60, idx);
        check("late requester next", 32'(idx), 32'd1);
        req_valid[1] = 1'b0;
        wait_grant(60, idx);
        check("stream resumes", 32'(idx), 32'd0);
        req_valid = '0;
        wait_idle(100);

        // Tick in the accept cycle must not start the frame.
        do_reset();
        for (int k = 0; k < 10 && txclk_en !== 1'b1; k++) cyc();
        req_byte[0] = 8'h5B;
        req_valid   = 2'b01;
        @(negedge clk);
        check("coincident ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #2;
        req_valid = '0;
        n = 0;
        while (tx !== 1'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("coincident start delay", 32'(n), 32'd5);
        m = 0;
        while (tx === 1'b0 && m < 40) begin
            @(negedge clk);
            m++;
        end
        check("coincident start length", 32'(m), 32'd4);
        wait_idle(100);

        // Reset during data bit 3 of a frame from requester 1.
        do_reset();
        req_byte[1] = 8'hC3;
        req_valid   = 2'b10;
        wait_grant(6, idx);
        check("pre-reset grant", 32'(idx), 32'd1);
        req_valid = '0;
        for (int k = 0; k < 100 && !(m_busy && m_tl == 6); k++) cyc();
        req_valid = 2'b11;
        #1;
        reset = 1'b1;
        #1;
        check("mid-frame reset outputs", 32'({req_ready, busy, tx, grant_id}), 32'({2'b00, 1'b0, 1'b1, 1'b0}));
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("post-reset priority", 32'(req_ready), 32'd1);
        cyc();
        req_valid = '0;
        wait_idle(100);

        // One-cycle request while busy is withdrawn and never served.
        do_reset();
        req_byte[0] = 8'h96;
        req_valid   = 2'b01;
        wait_grant(6, idx);
        req_valid = '0;
        base = ready_cnt;
        repeat (8) cyc();
        req_byte[1]  = 8'hEE;
        req_valid[1] = 1'b1;
        cyc();
        req_valid[1] = 1'b0;
        wait_idle(100);
        repeat (60) cyc();
        check("withdrawn request", 32'(ready_cnt - base), 32'd0);

        // Randomized requesters against the model, varying tick period.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            cyc();
            if (c % 500 == 0) tick_p = $urandom_range(3, 6);
            for (int i = 0; i < N; i++) begin
                if (ready_seen[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    req_byte[i]  = 8'($urandom);
                end else if (req_valid[i]) begin
                    if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 7) == 0) begin
                    req_valid[i] = 1'b1;
                    req_byte[i]  = 8'($urandom);
                end
            end
        end
        req_valid = '0;
        wait_idle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Shares one UART transmit serializer between NUM_REQ byte requesters using round-robin arbitration.
- Consumes the 115200-baud txclk_en tick from the existing baud-rate generator and drives the serial tx line (8N1, LSB first).
- Sits between on-chip byte sources (e.g. debug console, CPU UART register) and the tx pad.

Parameters:
- NUM_REQ, 2, number of requesters (legal range 2..8).
- DATA_BITS, 8, bits per frame. Fixed at 8; carried as a parameter for clarity only.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- txclk_en  input  1  one-cycle baud tick; one bit period = interval between ticks.
- req_valid  input  NUM_REQ  per-requester byte-available flag.
- req_data  input  NUM_REQ*8  packed bytes; requester i occupies bits [8i+7:8i].
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
- tx  output  1  serial line, idle high.
- busy  output  1  high from accept until frame end (the cycle the FSM returns to IDLE).
- grant_id  output  $clog2(NUM_REQ)  index of the last accepted requester.

Behaviour:
- Reset values: tx=1, req_ready=0, busy=0, grant_id=0, FSM=IDLE, bit counter=0, rr pointer=NUM_REQ-1 so requester 0 wins first.
- Reset asserted mid-frame: all outputs take their reset values immediately. The frame is abandoned and no ready pulse is issued.
- Handshake: a transfer occurs when req_valid[i] & req_ready[i]. The requester holds valid and data stable until ready. Dropping valid before ready is legal and causes no transfer.
- At most one req_ready bit is high in any cycle. A ready pulse occurs only in IDLE.
- FSM states: IDLE, PENDING, START, DATA, STOP.
- IDLE, tx=1:
  - If any valid is set, the round-robin winner is the first valid index strictly after the pointer, wrapping modulo NUM_REQ.
  - In the same cycle: req_ready[winner]=1 and the byte is latched into an 8-bit shift register.
  - Next cycle: grant_id=winner, pointer=winner, busy=1, state=PENDING.
  - txclk_en is ignored in IDLE, including a tick in the accept cycle.
- PENDING, tx=1: on txclk_en go to START. This aligns the start bit to a tick so every bit lasts exactly one tick period.
- START, tx=0: on txclk_en go to DATA with bit counter=0.
- DATA, tx=shift[0]: on txclk_en shift right and increment the counter. When counter==7 on a tick, go to STOP.
- STOP, tx=1: on txclk_en go to IDLE and clear busy in that same transition.
- Re-arbitration in the first IDLE cycle: a new accept can happen then, giving a minimum of one idle clock between frames. The extra PENDING wait keeps frames tick-aligned.
- Latency: ready pulse to start bit = 1 clock plus wait for next tick (≤ 1 tick period + 1 clock).
- Frame length: exactly 10 tick periods (start, 8 data, stop).
- Widths: bit counter is 3 bits and wraps only via state exit. Pointer arithmetic is modulo NUM_REQ with no out-of-range indices.
- tx is driven from a register and is glitch-free.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum {IDLE, PENDING, START, DATA, STOP}.
  - UART_DATA_BITS=8.
  - UART_BAUD=115200 constant, shared with the baud-rate generator.
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], pointer, enable.
  - Outputs: one-hot grant[N], binary grant index.
  - Combinational; its pointer register lives in the parent.

Test Plan:
- Single byte: txclk_en every 4 clocks, req_valid[0]=1, data 0xA5 -> one req_ready[0] pulse, grant_id=0, then tx = 0,1,0,1,0,0,1,0,1,1, each held exactly 4 clocks. busy falls at STOP end.
- Contention: req0=0x11 and req1=0x22 both valid from reset -> req0 served first, then req1. With both still valid afterwards, the order continues 0,1,0,1. grant_id tracks each grant.
- Starvation check: req0 streams continuously and req1 asserts once mid-frame -> req1 is granted at the very next IDLE and never waits more than one frame.
- Tick coincident with accept: txclk_en high in the accept cycle -> FSM enters PENDING and the start bit begins on the following tick, not that one. Start bit lasts a full tick period.
- Reset mid-frame: assert reset during DATA bit 3 -> tx=1, busy=0, req_ready=0 immediately. After release, requester 0 has priority again.
- Withdrawn request: req_valid[1] pulses for one cycle while busy -> no req_ready[1] and no frame transmitted.
